iic_slave_regs: RTL and testbench

IIC_SLAVE_REGS -- requirements
Module: iic_slave_regs

---
 rtl/iic_slave_regs.sv | 240 ++++++++++++++++++++++++
 tb/tb_iic_slave_regs.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_slave_regs.sv
// I2C target exposing a 128x8 register file with an auto-incrementing pointer,
// a read-only WHO_AM_I register and a local sample-load port.
module iic_slave_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter logic [7:0] WHO_AM_I = 8'h68
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       upd_en,
  input  logic [6:0] upd_addr,
  input  logic [7:0] upd_data,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);
  localparam int unsigned AW   = 7;
  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 128;
  localparam int unsigned CW   = 4;
  localparam logic [AW-1:0] WHO_IDX = 7'h75;
  localparam logic [AW-1:0] PWR_IDX = 7'h6B;
  localparam logic [DW-1:0] PWR_RST = 8'h40;
  localparam logic [CW-1:0] BYTE_BITS = 4'd8;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  bit_cnt, bit_cnt_n;
  logic [DW-1:0]  shift, shift_n;
  logic [AW-1:0]  ptr, ptr_n;
  logic           rw, rw_n;
  logic           mack, mack_n;
  logic           sda_oe_n, busy_n, wr_strobe_n;
  logic [AW-1:0]  wr_addr_n;
  logic [DW-1:0]  wr_data_n;
  logic           reg_we_c;
  logic [DW-1:0]  regs [NREG];

  // Bus synchronizers plus one history stage; reset to the idle-bus level
  logic scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= scl_i; scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= sda_i; sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  logic scl_rise_c, scl_fall_c, start_c, stop_c, shift_in_c, byte_done_c;
  assign scl_rise_c  = scl_s2 & ~scl_d;
  assign scl_fall_c  = ~scl_s2 & scl_d;
  assign start_c     = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_c      = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign shift_in_c  = scl_rise_c && (bit_cnt != BYTE_BITS);
  assign byte_done_c = scl_fall_c && (bit_cnt == BYTE_BITS);

  logic [AW-1:0] rd_idx_c;
  logic [DW-1:0] rd_data_c;
  assign rd_idx_c  = (state == MACK) ? ptr + 7'd1 : ptr;
  assign rd_data_c = (rd_idx_c == WHO_IDX) ? WHO_AM_I : regs[rd_idx_c];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      mack      <= 1'b1;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      ptr       <= ptr_n;
      rw        <= rw_n;
      mack      <= mack_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      wr_strobe <= wr_strobe_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
    end
  end

  // Protocol FSM: bits sampled on SCL rise, SDA drive changes only on SCL fall
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    ptr_n       = ptr;
    rw_n        = rw;
    mack_n      = mack;
    sda_oe_n    = sda_oe;
    busy_n      = busy;
    wr_strobe_n = 1'b0;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    reg_we_c    = 1'b0;
    if (stop_c) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (start_c) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (shift_in_c) begin
            shift_n   = {shift[6:0], sda_s2};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (byte_done_c) begin
            bit_cnt_n = '0;
            if (shift[7:1] == DEV_ADDR) begin
              state_n  = ADDR_ACK;
              rw_n     = shift[0];
              sda_oe_n = 1'b1;
              busy_n   = 1'b1;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall_c) begin
            if (rw) begin
              state_n  = RDATA;
              shift_n  = rd_data_c;
              sda_oe_n = ~rd_data_c[7];
            end else begin
              state_n  = PTR;
              sda_oe_n = 1'b0;
            end
          end
        end
        PTR: begin
          if (shift_in_c) begin
            shift_n   = {shift[6:0], sda_s2};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (byte_done_c) begin
            bit_cnt_n = '0;
            ptr_n     = shift[6:0];
            state_n   = PTR_ACK;
            sda_oe_n  = 1'b1;
          end
        end
        PTR_ACK: begin
          if (scl_fall_c) begin
            state_n  = WDATA;
            sda_oe_n = 1'b0;
          end
        end
        WDATA: begin
          if (shift_in_c) begin
            shift_n   = {shift[6:0], sda_s2};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (byte_done_c) begin
            bit_cnt_n = '0;
            state_n   = WDATA_ACK;
            sda_oe_n  = 1'b1;
          end
        end
        WDATA_ACK: begin
          // Commit at the end of the ACK clock; WHO_AM_I is acked but never stored
          if (scl_fall_c) begin
            state_n  = WDATA;
            sda_oe_n = 1'b0;
            ptr_n    = ptr + 7'd1;
            if (ptr != WHO_IDX) begin
              reg_we_c    = 1'b1;
              wr_strobe_n = 1'b1;
              wr_addr_n   = ptr;
              wr_data_n   = shift;
            end
          end
        end
        RDATA: begin
          if (shift_in_c) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (byte_done_c) begin
            bit_cnt_n = '0;
            state_n   = MACK;
            sda_oe_n  = 1'b0;
          end else if (scl_fall_c) begin
            shift_n  = {shift[6:0], 1'b0};
            sda_oe_n = ~shift[6];
          end
        end
        MACK: begin
          if (scl_rise_c) begin
            mack_n = sda_s2;
          end else if (scl_fall_c) begin
            ptr_n = ptr + 7'd1;
            if (!mack) begin
              state_n  = RDATA;
              shift_n  = rd_data_c;
              sda_oe_n = ~rd_data_c[7];
            end else begin
              state_n  = IDLE;
              sda_oe_n = 1'b0;
              busy_n   = 1'b0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Register file: the I2C write takes priority over a same-cycle local load
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[AW'(i)] <= (AW'(i) == PWR_IDX) ? PWR_RST : '0;
      end
    end else if (reg_we_c) begin
      regs[ptr] <= shift;
    end else if (upd_en && (upd_addr != WHO_IDX)) begin
      regs[upd_addr] <= upd_data;
    end
  end

endmodule

// File: tb/tb_iic_slave_regs.sv
// Bit-banged I2C master driving iic_slave_regs, checked against a register-map model.
module tb_iic_slave_regs;
  localparam int unsigned H = 5;
  localparam logic [6:0] DEV = 7'h68;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe;
  logic       upd_en = 1'b0;
  logic [6:0] upd_addr = '0;
  logic [7:0] upd_data = '0;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  always #10 clk = ~clk;

  iic_slave_regs dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .upd_en   (upd_en),
    .upd_addr (upd_addr),
    .upd_data (upd_data),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  typedef struct packed {logic [6:0] a; logic [7:0] d;} wr_t;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] m_regs [128];
  logic [6:0] m_ptr;
  wr_t        exp_q[$];
  wr_t        got_q[$];
  int         sb_idx = 0;
  int         oe_cnt = 0;
  int         busy_cnt = 0;
  logic [7:0] wdat[$];

  always @(negedge clk) begin
    if (wr_strobe) got_q.push_back('{wr_addr, wr_data});
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register-map reference: plain array, WHO_AM_I fixed, pointer wraps at 7 bits
  function automatic void m_reset();
    for (int i = 0; i < 128; i++) m_regs[i] = 8'h00;
    m_regs[8'h6B] = 8'h40;
    m_regs[8'h75] = 8'h68;
    m_ptr = 7'h00;
  endfunction

  function automatic void m_write(input logic [6:0] a, input logic [7:0] d);
    if (a != 7'h75) begin
      m_regs[a] = d;
      exp_q.push_back('{a, d});
    end
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rw_bit(input logic b, output logic s);
    tick(H); sda_m = b; tick(H); scl = 1'b1; tick(H); s = sda_bus; tick(H); scl = 1'b0;
  endtask

  task automatic i2c_start();
    tick(H); sda_m = 1'b1; tick(H); scl = 1'b1; tick(H); sda_m = 1'b0; tick(H); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(H); sda_m = 1'b0; tick(H); scl = 1'b1; tick(H); sda_m = 1'b1; tick(H);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) rw_bit(b[i], s);
    rw_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic give_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      rw_bit(1'b1, s);
      b[i] = s;
    end
    rw_bit(~give_ack, s);
  endtask

  task automatic upd(input logic [6:0] a, input logic [7:0] d);
    upd_addr = a; upd_data = d; upd_en = 1'b1;
    tick(1);
    upd_en = 1'b0;
    if (a != 7'h75) m_regs[a] = d;
  endtask

  task automatic check_strobes();
    check("strobe_cnt", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = sb_idx; i < exp_q.size() && i < got_q.size(); i++)
      check("strobe_val", 32'(got_q[i]), 32'(exp_q[i]));
    sb_idx = (exp_q.size() > got_q.size()) ? exp_q.size() : got_q.size();
  endtask

  task automatic set_ptr(input logic [6:0] p);
    logic ack;
    i2c_start();
    write_byte({DEV, 1'b0}, ack); check("w_addr_ack", 32'(ack), 1);
    check("busy_mid", 32'(busy), 1);
    write_byte({1'b0, p}, ack);   check("ptr_ack", 32'(ack), 1);
    m_ptr = p;
  endtask

  task automatic do_write(input logic [6:0] p);
    logic ack;
    set_ptr(p);
    foreach (wdat[i]) begin
      write_byte(wdat[i], ack);
      check("w_data_ack", 32'(ack), 1);
      m_write(m_ptr, wdat[i]);
      m_ptr++;
    end
    i2c_stop();
    tick(4);
    check("busy_after_stop", 32'(busy), 0);
    check_strobes();
  endtask

  task automatic read_body(input int unsigned n);
    logic ack;
    logic [7:0] b;
    write_byte({DEV, 1'b1}, ack); check("r_addr_ack", 32'(ack), 1);
    for (int unsigned k = 0; k < n; k++) begin
      read_byte(k != n - 1, b);
      check("rd_data", 32'(b), 32'(m_regs[m_ptr]));
      m_ptr++;
    end
    i2c_stop();
    tick(4);
    check("busy_after_read", 32'(busy), 0);
  endtask

  task automatic do_read(input logic [6:0] p, input int unsigned n);
    set_ptr(p);
    i2c_start();
    read_body(n);
  endtask

  task automatic cur_read(input int unsigned n);
    i2c_start();
    read_body(n);
  endtask

  task automatic wrong_addr(input logic [6:0] a);
    logic ack;
    int oe0, bz0;
    oe0 = oe_cnt; bz0 = busy_cnt;
    i2c_start();
    write_byte({a, 1'b0}, ack); check("nack_addr", 32'(ack), 0);
    write_byte(8'h3B, ack);     check("nack_ptr", 32'(ack), 0);
    write_byte(8'h5A, ack);     check("nack_data", 32'(ack), 0);
    i2c_stop();
    tick(4);
    check("nack_oe_cycles", 32'(oe_cnt - oe0), 0);
    check("nack_busy_cycles", 32'(busy_cnt - bz0), 0);
    check_strobes();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ack, s;
    logic [7:0] b;
    logic [6:0] p;
    int unsigned op, n;

    m_reset();
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_strobe", 32'(wr_strobe), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);

    // Power register reset value, then the basic single-byte write
    do_read(7'h6B, 1);
    wdat = '{8'h00};
    do_write(7'h6B);
    do_read(7'h6B, 1);

    // Burst read across locally loaded samples; follow-up current read proves final pointer
    for (int i = 0; i < 6; i++) upd(7'(8'h3B + i), 8'(8'h11 + i));
    upd(7'h41, 8'h77);
    do_read(7'h3B, 6);
    cur_read(1);

    wrong_addr(7'h69);

    // WHO_AM_I is readable and write-protected
    do_read(7'h75, 1);
    wdat = '{8'hFF};
    do_write(7'h75);
    do_read(7'h75, 1);

    // Pointer wrap
    wdat = '{8'hAA, 8'hBB};
    do_write(7'h7F);
    do_read(7'h7F, 2);

    // Local load during a read byte must not change the byte in flight
    upd(7'h10, 8'h5A);
    set_ptr(7'h10);
    i2c_start();
    write_byte({DEV, 1'b1}, ack); check("r_addr_ack", 32'(ack), 1);
    fork
      begin
        logic [7:0] rb;
        read_byte(1'b0, rb);
        check("rd_latched", 32'(rb), 32'h5A);
      end
      begin
        tick(30);
        upd(7'h10, 8'hC3);
      end
    join
    i2c_stop();
    m_ptr = 7'h11;
    do_read(7'h10, 1);

    // Same-cycle local load and I2C write to one address: I2C data must land
    set_ptr(7'h22);
    fork
      begin
        logic a2;
        write_byte(8'h5C, a2);
        check("coll_ack", 32'(a2), 1);
      end
      begin
        int unsigned t;
        t = 0;
        upd_addr = 7'h22; upd_data = 8'h99; upd_en = 1'b1;
        tick(1);
        while (!wr_strobe && t < 400) begin
          tick(1);
          t++;
        end
        upd_en = 1'b0;
        check("coll_strobe_seen", 32'(t < 400), 1);
      end
    join
    m_regs[7'h22] = 8'h99;
    m_write(7'h22, 8'h5C);
    m_ptr = 7'h23;
    i2c_stop();
    tick(4);
    check_strobes();
    do_read(7'h22, 1);

    // STOP after half a data byte discards it
    upd(7'h30, 8'h3C);
    set_ptr(7'h30);
    for (int i = 0; i < 4; i++) rw_bit(1'b0, s);
    i2c_stop();
    tick(4);
    check("abort_busy", 32'(busy), 0);
    check_strobes();
    do_read(7'h30, 1);

    // Randomized traffic
    for (int it = 0; it < 25; it++) begin
      op = $urandom_range(0, 4);
      p  = 7'($urandom_range(0, 127));
      n  = $urandom_range(1, 3);
      case (op)
        0: upd(p, 8'($urandom_range(0, 255)));
        1: begin
          wdat.delete();
          for (int unsigned k = 0; k < n; k++) wdat.push_back(8'($urandom_range(0, 255)));
          do_write(p);
        end
        2: do_read(p, n + 1);
        3: cur_read(n);
        default: wrong_addr((p == DEV) ? p ^ 7'h01 : p);
      endcase
    end

    // Reset while the target is driving a zero read bit
    upd(7'h50, 8'h00);
    set_ptr(7'h50);
    i2c_start();
    write_byte({DEV, 1'b1}, ack); check("r_addr_ack", 32'(ack), 1);
    for (int i = 0; i < 4; i++) rw_bit(1'b1, s);
    tick(H);
    check("oe_before_rst", 32'(sda_oe), 1);
    rst = 1'b1;
    tick(1);
    check("oe_after_rst", 32'(sda_oe), 0);
    check("busy_after_rst", 32'(busy), 0);
    rst = 1'b0;
    m_reset();
    i2c_stop();
    tick(4);
    check("rst_wr_addr2", 32'(wr_addr), 0);
    do_read(7'h6B, 1);
    do_read(7'h50, 1);
    check_strobes();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
